adder_slice_scheduler: RTL and testbench
========================================

Name: adder_slice_scheduler

Overview:
- Shares one B-bit ripple-carry slice between two requesters, each issuing N-bit add/subtract operations.
- Sequences the slice over N/B cycles, carrying between slices in a register, then presents the full result on a valid/ready output port.
- Sits beside the wide combinational adders as the area-lean, multi-cycle alternative for non-critical arithmetic.

Parameters:
- N, 128, operand/result width; N % B == 0 required.
- B, 32, slice width processed per cycle; S = N/B slice steps per operation.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted this cycle when valid&ready
- req0_a  input  N  operand A, requester 0
- req0_b  input  N  operand B, requester 0
- req0_sub  input  1  1 = A-B, 0 = A+B, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions and widths as requester 0, for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result when valid&ready
- res_sum  output  N  A+B or A-B, modulo 2^N
- res_cout  output  1  carry out; for subtract, 1 = no borrow (A>=B unsigned)
- res_id  output  1  requester index that issued this result
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; res_valid=0; res_sum=0; res_cout=0; res_id=0; busy=0; slice index=0; last-served pointer=1, so requester 0 wins the first tie. Assertion mid-operation aborts it; the result is discarded and never presented.
- FSM IDLE:
  - reqX_ready = (state==IDLE) & grantX; ready is combinational from state, both valids and the pointer.
  - Grant rule: only one valid -> that requester; both valid -> the requester not last served; none -> no grant.
  - On handshake: latch A, B^{N{sub}} and cin=sub; set res_id and the pointer to the winner; index=0; go RUN.
- FSM RUN, step k = 0..S-1, one per cycle:
  - Slice adds A[k*B+:B] + B'[k*B+:B] + carry.
  - Writes the sum slice into the result register; carry register <= slice carry-out.
  - After step S-1: res_cout <= final carry; go DONE.
- FSM DONE:
  - res_valid=1; res_sum, res_cout and res_id held stable until res_ready.
  - On res_valid&res_ready: next edge -> IDLE, res_valid=0.
- Latency: handshake at edge E0; res_valid high after edge E0+S; earliest next acceptance one cycle after result handshake. Throughput = one operation per S+2 cycles minimum.
- No acceptance in RUN or DONE: both readys are 0; requesters hold valid and operands (standard valid/ready; valid must not drop before ready).
- res_sum during RUN shows partial data; it is defined only while res_valid=1.
- The pointer updates only on acceptance, never on idle cycles.
- B==N (S=1) is legal: single RUN cycle.

Test Plan:
- Requester 0 only, A=2^128-1, B=1, add -> req0_ready pulses once; res_valid 4 cycles after handshake (N=128, B=32); res_sum=0, res_cout=1, res_id=0. Carry crosses all slice boundaries.
- Requester 1, A=5, B=7, sub=1 -> res_sum=2^128-2, res_cout=0 (borrow), res_id=1; A=7, B=5 sub -> res_sum=2, res_cout=1.
- Both valid continuously, four ops each, res_ready=1 -> grants alternate 0,1,0,1,...; first grant to 0; results in issue order; ops spaced 6 cycles.
- res_ready held 0 for 10 cycles in DONE -> res_sum, res_cout and res_id stable; both readys 0; no new acceptance; release -> IDLE next edge, then acceptance.
- rst_n driven low during RUN step 2 -> outputs zero immediately (asynchronous); after release, new op A=3, B=4 -> res_sum=7, pointer back to reset value (requester 0 wins tie).
- Random A/B/sub on both ports, random res_ready -> every result matches the reference (A±B) mod 2^N and the carry/borrow; no lost or duplicated operations.

Source files
------------

// File: rtl/adder_slice_scheduler.sv
// adder_slice_scheduler
// Two requesters share a single B-bit ripple-carry slice. An accepted N-bit
// add/subtract is walked through the slice over S = N/B cycles. The carry
// between slices is held in a register. The finished result is then offered
// on a valid/ready port. Subtraction is done as A + ~B + 1. N must be a
// multiple of B.

module adder_slice_scheduler #(
   parameter int N = 128,
   parameter int B = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req0_sub,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic         req1_sub,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_sum,
   output logic         res_cout,
   output logic         res_id,
   output logic         busy
);

   localparam int S  = N / B;
   localparam int IW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;       // operand B, already inverted for subtract
   logic [N-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          id_q, id_d;
   logic          ptr_q, ptr_d;   // requester served most recently
   logic [IW-1:0] idx_q, idx_d;

   logic          grant0, grant1, accept, win_id, win_sub, last_step;
   logic [N-1:0]  win_a, win_b;
   logic [B:0]    slice_s;

   // Round-robin grant: a lone requester always wins, and a tie goes to the
   // requester that was not served last.
   assign grant0 = req0_valid & (~req1_valid | ptr_q);
   assign grant1 = req1_valid & (~req0_valid | ~ptr_q);

   // The readys are mutually exclusive, so req1_ready alone names the winner.
   assign accept  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign win_id  = req1_ready;
   assign win_a   = win_id ? req1_a   : req0_a;
   assign win_b   = win_id ? req1_b   : req0_b;
   assign win_sub = win_id ? req1_sub : req0_sub;

   assign last_step = (idx_q == IW'(S - 1));

   // The one shared slice: the current B-bit chunk plus the carry left by the
   // chunk below it.
   assign slice_s = {1'b0, a_q[idx_q*B +: B]} + {1'b0, b_q[idx_q*B +: B]}
                  + {{B{1'b0}}, carry_q};

   assign res_sum  = sum_q;
   assign res_cout = cout_q;
   assign res_id   = id_q;

   // State register; an asynchronous reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: state updates use non-blocking assignment, so every register
         // in this clock domain samples pre-edge values regardless of block
         // order.
         state_q <= state_d;
      end
   end

   // Next state: accept in IDLE, run S slice steps, then hold until consumed.
   always_comb begin
      // NOTE: defaulting every comb output first makes each path assign it,
      // so no latch can be inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last_step) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Port handshakes decoded from the state and the arbiter.
   always_comb begin
      req0_ready = (state_q == IDLE) & grant0;
      req1_ready = (state_q == IDLE) & grant1;
      res_valid  = (state_q == DONE);
      busy       = (state_q != IDLE);
   end

   // Datapath next-state: operands are latched on acceptance, then one
   // result slice is produced per RUN cycle.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      if (accept) begin
         a_d     = win_a;
         b_d     = win_b ^ {N{win_sub}};
         carry_d = win_sub;
         id_d    = win_id;
         ptr_d   = win_id;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         sum_d[idx_q*B +: B] = slice_s[B-1:0];
         carry_d             = slice_s[B];
         if (last_step) begin
            cout_d = slice_s[B];
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
   end

   // Datapath registers. The reset pointer of 1 lets requester 0 win the
   // first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the wide operand and result registers are ordinary flops
         // rather than memories, so they are reset here and res_sum reads 0
         // straight out of reset.
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         ptr_q   <= 1'b1;
         idx_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_adder_slice_scheduler.sv
// Testbench for adder_slice_scheduler.
// An acceptance observer pushes the expected result of each granted operation
// into a scoreboard. A result monitor pops entries and compares them with the
// DUT outputs. Arbitration, latency and result hold behaviour are checked
// against plain arithmetic and round-robin rules.

module tb_adder_slice_scheduler;

   localparam int N = 128;
   localparam int B = 32;
   localparam int S = N / B;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_sub;
   logic [N-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_sub;
   logic [N-1:0] req1_a, req1_b;
   logic         res_valid, res_ready, res_cout, res_id, busy;
   logic [N-1:0] res_sum;

   typedef struct {
      logic [N-1:0] sum;
      logic         cout;
      logic         id;
      int           hs_cyc;
   } exp_t;

   typedef struct {
      int   cyc;
      logic id;
   } hs_t;

   exp_t sb[$];
   hs_t  hs_log[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_sent   = 0;
   int   n_popped = 0;
   int   last_take_cyc = 0;
   logic mptr = 1'b1;
   int   rr_mode = 0;
   logic rr_val  = 1'b1;

   adder_slice_scheduler #(.N(N), .B(B)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain N-bit arithmetic; for subtract, carry-out means A >= B.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic sub, input logic id, input int c);
      exp_t         r;
      logic [N:0]   w;
      if (sub) begin
         r.sum  = a - b;
         r.cout = (a >= b);
      end else begin
         w      = {1'b0, a} + {1'b0, b};
         r.sum  = w[N-1:0];
         r.cout = w[N];
      end
      r.id     = id;
      r.hs_cyc = c;
      return r;
   endfunction

   function automatic logic [N-1:0] rnd_val();
      logic [N-1:0] v;
      case ($urandom_range(0, 4))
         0:       v = '1;
         1:       v = '0;
         default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
      return v;
   endfunction

   // res_ready driver: a fixed level or a random level each cycle.
   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         res_ready = (rr_mode == 1) ? 1'($urandom_range(0, 1)) : rr_val;
      end
   end

   // Acceptance observer and result monitor, sampled on the falling edge.
   initial begin
      logic         pv, pr, pc, pid, exp_w, win;
      logic [N-1:0] ps;
      exp_t         e;
      pv = 1'b0; pr = 1'b0; pc = 1'b0; pid = 1'b0; ps = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            mptr = 1'b1;
            pv   = 1'b0;
            pr   = 1'b0;
            continue;
         end
         if (pv && !pr) begin
            check("hold_valid", res_valid, 1);
            check("hold_sum", res_sum, ps);
            check("hold_cout", res_cout, pc);
            check("hold_id", res_id, pid);
         end
         if (res_valid && !pv) begin
            check("result_expected", sb.size() != 0, 1);
            if (sb.size() != 0) check("latency", cyc - sb[0].hs_cyc, S + 1);
         end
         if (res_valid && res_ready) begin
            check("result_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("res_sum", res_sum, e.sum);
               check("res_cout", res_cout, e.cout);
               check("res_id", res_id, e.id);
               n_popped++;
               last_take_cyc = cyc;
            end
         end
         if (busy) check("ready_low_when_busy", {req1_ready, req0_ready}, 0);
         if (!busy && (req0_valid || req1_valid))
            check("grant_present", req0_ready | req1_ready, 1);
         if (req0_ready || req1_ready) begin
            check("single_grant", req0_ready & req1_ready, 0);
            exp_w = (req0_valid && req1_valid) ? ~mptr : req1_valid;
            check("grant_winner", req1_ready, exp_w);
            win = req1_ready;
            if (win) sb.push_back(model(req1_a, req1_b, req1_sub, 1'b1, cyc));
            else     sb.push_back(model(req0_a, req0_b, req0_sub, 1'b0, cyc));
            hs_log.push_back('{cyc: cyc, id: win});
            mptr = win;
         end
         pv = res_valid; pr = res_ready; ps = res_sum; pc = res_cout; pid = res_id;
      end
   end

   // Present one operation and hold it until accepted; entered and left at
   // posedge+1.
   task automatic send(input int p, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      if (p == 0) begin
         req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
      end
      n_sent++;
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? req0_ready : req1_ready;
      end
      check("send_handshake", got, 1);
      @(posedge clk);
      #1;
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic send_rnd(input int p);
      send(p, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", (sb.size() == 0) && !busy, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int n;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_sum", res_sum, 0);
      check("rst_res_cout", res_cout, 0);
      check("rst_res_id", res_id, 0);
      check("rst_busy", busy, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Carry ripples through every slice boundary.
      send(0, '1, 1, 1'b0);
      wait_drain();

      // Subtract with and without borrow from requester 1.
      send(1, 5, 7, 1'b1);
      wait_drain();
      send(1, 7, 5, 1'b1);
      wait_drain();

      // Both requesters continuously valid: grants alternate from 0.
      base = hs_log.size();
      fork
         for (int i = 0; i < 4; i++) send_rnd(0);
         for (int i = 0; i < 4; i++) send_rnd(1);
      join
      wait_drain();
      check("alt_count", hs_log.size() - base, 8);
      if (hs_log.size() >= base + 8) begin
         for (int i = 0; i < 8; i++) begin
            check("alt_winner", hs_log[base+i].id, i % 2);
            if (i > 0) check("alt_spacing", hs_log[base+i].cyc - hs_log[base+i-1].cyc, S + 2);
         end
      end

      // Back-pressure: result held for 10 cycles, no acceptance meanwhile.
      rr_val = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_rnd(0);
      fork
         send_rnd(1);
         begin
            n = 0;
            while (!res_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            check("bp_valid_seen", res_valid, 1);
            repeat (10) begin
               @(negedge clk);
               check("bp_valid_held", res_valid, 1);
               check("bp_no_accept", {req1_ready, req0_ready}, 0);
            end
            rr_val = 1'b1;
         end
      join
      check("bp_accept_id", hs_log[hs_log.size()-1].id, 1);
      check("bp_accept_cycle", hs_log[hs_log.size()-1].cyc, last_take_cyc + 1);
      wait_drain();

      // Reset asserted during RUN step 2 discards the operation.
      send_rnd(0);
      @(posedge clk);
      @(posedge clk);
      #3;
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_res_sum", res_sum, 0);
      check("mid_rst_res_cout", res_cout, 0);
      check("mid_rst_res_id", res_id, 0);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = hs_log.size();
      fork
         send(0, 3, 4, 1'b0);
         send_rnd(1);
      join
      wait_drain();
      check("post_rst_count", hs_log.size() - base, 2);
      if (hs_log.size() >= base + 1) check("post_rst_first_grant", hs_log[base].id, 0);

      // Random traffic with random back-pressure.
      rr_mode = 1;
      fork
         for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if (!req0_valid) #1;
            send_rnd(0);
         end
         for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if (!req1_valid) #1;
            send_rnd(1);
         end
      join
      rr_mode = 0;
      rr_val  = 1'b1;
      wait_drain();

      check("op_count", n_popped, n_sent - 1);
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
